// File: rtl/tage_alloc_scheduler.sv
// TAGE allocation / useful-counter maintenance scheduler.
// Takes resolved-branch updates and decides whether a mispredicted branch
// gets a new entry in a longer-history tagged component (ALLOC) or whether
// the useful counters of the longer components are aged instead (DECAY).
// A free-running period counter periodically triggers a full sweep that
// clears every useful counter, one index per cycle (SWEEP).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   upd_valid/upd_ready      update handshake from the exec stage
//   upd_mispredict           final prediction was wrong
//   upd_provider             provider component (0 = bimodal)
//   upd_index                hashed index of the branch
//   useful_rdata             useful counters of components 1..N_TAGGED
//   tbl_index                write index to all tagged components
//   alloc_we                 one-hot allocate strobe
//   useful_dec, useful_clr   decrement / clear useful strobes
//   busy                     scheduler is not idle
module tage_alloc_scheduler #(
  parameter int unsigned N_TAGGED          = 4,
  parameter int unsigned INDEX_LEN         = 9,
  parameter int unsigned USEFUL_LEN        = 2,
  parameter int unsigned RESET_COUNTER_LEN = 18
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           upd_valid,
  output logic                           upd_ready,
  input  logic                           upd_mispredict,
  input  logic [2:0]                     upd_provider,
  input  logic [INDEX_LEN-1:0]           upd_index,
  input  logic [N_TAGGED*USEFUL_LEN-1:0] useful_rdata,
  output logic [INDEX_LEN-1:0]           tbl_index,
  output logic [N_TAGGED-1:0]            alloc_we,
  output logic [N_TAGGED-1:0]            useful_dec,
  output logic [N_TAGGED-1:0]            useful_clr,
  output logic                           busy
);

  localparam logic [INDEX_LEN-1:0]         PTR_ONE    = INDEX_LEN'(1);
  localparam logic [RESET_COUNTER_LEN-1:0] PERIOD_ONE = RESET_COUNTER_LEN'(1);

  typedef enum logic [1:0] {IDLE, ALLOC, DECAY, SWEEP} state_t;

  state_t                       state_q, state_d;
  logic [RESET_COUNTER_LEN-1:0] period_q;
  logic                         pending_q;
  logic [INDEX_LEN-1:0]         sweep_ptr_q;
  logic [7:0]                   lfsr_q;
  logic [INDEX_LEN-1:0]         lat_index_q;
  logic [N_TAGGED-1:0]          lat_mask_q;

  logic [N_TAGGED-1:0] above, cand, pick_first, pick_second, chosen;
  logic [1:0]          n_found;
  logic                act, wrap, sweep_last;

  // Candidate search: bit j stands for component j+1, so "j+1 > provider"
  // is "provider <= j"; providers >= N_TAGGED naturally yield no bits.
  always_comb begin
    above       = '0;
    cand        = '0;
    pick_first  = '0;
    pick_second = '0;
    n_found     = 2'd0;
    for (int j = 0; j < int'(N_TAGGED); j++) begin
      above[j] = (upd_provider <= 3'(j));
      cand[j]  = above[j] && (useful_rdata[j*USEFUL_LEN +: USEFUL_LEN] == '0);
      if (cand[j] && (n_found != 2'd2)) begin
        if (n_found == 2'd0) pick_first[j]  = 1'b1;
        else                 pick_second[j] = 1'b1;
        n_found = n_found + 2'd1;
      end
    end
    chosen = ((pick_second != '0) && lfsr_q[0]) ? pick_second : pick_first;
  end

  assign act        = (state_q == IDLE) && !pending_q && upd_valid &&
                      upd_mispredict && (above != '0);
  assign wrap       = (state_q != SWEEP) && (period_q == '1);
  assign sweep_last = (state_q == SWEEP) && (sweep_ptr_q == '1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a pending sweep wins over any update request
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pending_q)       state_d = SWEEP;
        else if (act)        state_d = (cand != '0) ? ALLOC : DECAY;
      end
      ALLOC:                 state_d = IDLE;
      DECAY:                 state_d = IDLE;
      SWEEP: if (sweep_last) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Period counter, sweep bookkeeping, LFSR and latched request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q    <= '0;
      pending_q   <= 1'b0;
      sweep_ptr_q <= '0;
      lfsr_q      <= 8'h01;
      lat_index_q <= '0;
      lat_mask_q  <= '0;
    end else begin
      if (state_q != SWEEP) period_q <= period_q + PERIOD_ONE;
      if (sweep_last)       pending_q <= 1'b0;
      else if (wrap)        pending_q <= 1'b1;
      if (state_q == SWEEP) sweep_ptr_q <= sweep_ptr_q + PTR_ONE;
      // x^8 + x^6 + x^5 + x^4 + 1
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (act) begin
        lat_index_q <= upd_index;
        lat_mask_q  <= (cand != '0) ? chosen : above;
      end
    end
  end

  // Output decode from the current state
  always_comb begin
    upd_ready  = (state_q == IDLE) && !pending_q;
    busy       = (state_q != IDLE);
    tbl_index  = '0;
    alloc_we   = '0;
    useful_dec = '0;
    useful_clr = '0;
    case (state_q)
      ALLOC: begin
        alloc_we  = lat_mask_q;
        tbl_index = lat_index_q;
      end
      DECAY: begin
        useful_dec = lat_mask_q;
        tbl_index  = lat_index_q;
      end
      SWEEP: begin
        useful_clr = '1;
        tbl_index  = sweep_ptr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/tage_alloc_scheduler.md
TAGE_ALLOC_SCHEDULER -- requirements
Module: tage_alloc_scheduler

Interface
REQ-001 SHALL have parameter N_TAGGED, default 4, number of tagged components (component 1..N_TAGGED; component 0 is the bimodal table).
REQ-002 SHALL have parameter INDEX_LEN, default 9, tagged-table index width.
REQ-003 SHALL have parameter USEFUL_LEN, default 2, useful-counter width.
REQ-004 SHALL have parameter RESET_COUNTER_LEN, default 18, width of the useful-reset period counter.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; rst in 1, asynchronous active-low reset.
REQ-006 SHALL have port upd_valid, in, 1: resolved-branch update request from the exec stage.
REQ-007 SHALL have port upd_ready, out, 1: request accepted on a cycle with upd_valid & upd_ready.
REQ-008 SHALL have port upd_mispredict, in, 1: the final prediction was wrong.
REQ-009 SHALL have port upd_provider, in, 3: provider component number 0..N_TAGGED.
REQ-010 SHALL have port upd_index, in, INDEX_LEN: hashed index of the branch.
REQ-011 SHALL have port useful_rdata, in, N_TAGGED*USEFUL_LEN: useful counters of components 1..N_TAGGED at upd_index; component j occupies slice j-1; valid combinationally in the accept cycle.
REQ-012 SHALL have port tbl_index, out, INDEX_LEN: write index driven to all tagged components.
REQ-013 SHALL have port alloc_we, out, N_TAGGED: one-hot allocate strobe.
REQ-014 SHALL have port useful_dec, out, N_TAGGED: decrement-useful strobes.
REQ-015 SHALL have port useful_clr, out, N_TAGGED: clear-useful strobes.
REQ-016 SHALL have port busy, out, 1: high whenever state != IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ALLOC, DECAY, SWEEP.
REQ-018 upd_ready SHALL be 1 only in IDLE with sweep_pending=0.
REQ-019 On accept with upd_mispredict=0 or upd_provider=N_TAGGED: no action; state stays IDLE.
REQ-020 On accept with upd_mispredict=1 and upd_provider<N_TAGGED: candidates = components j>upd_provider with useful_rdata slice == 0.
REQ-021 If there is >=1 candidate, the block SHALL latch the chosen component and upd_index and go to ALLOC.
REQ-022 Chosen component SHALL be the lowest candidate, except that if >=2 candidates exist and lfsr[0]=1 it SHALL be the second-lowest.
REQ-023 If there are no candidates, the block SHALL latch the mask of all j>upd_provider and upd_index and go to DECAY.
REQ-024 ALLOC SHALL last exactly 1 cycle: alloc_we=one-hot(chosen), tbl_index=latched index; next state IDLE.
REQ-025 DECAY SHALL last exactly 1 cycle: useful_dec=latched mask, tbl_index=latched index; next state IDLE.
REQ-026 Outside ALLOC/DECAY/SWEEP, alloc_we, useful_dec and useful_clr SHALL be 0 and tbl_index SHALL be 0.
REQ-027 Period counter (RESET_COUNTER_LEN bits) SHALL increment every cycle not in SWEEP and hold during SWEEP.
REQ-028 The period counter SHALL set sweep_pending on wrap from all-ones to 0.
REQ-029 When in IDLE with sweep_pending=1, the FSM SHALL go to SWEEP; sweep SHALL take priority over a simultaneous upd_valid, which is not accepted.
REQ-030 SWEEP SHALL drive useful_clr=all ones and tbl_index=sweep_ptr.
REQ-031 In SWEEP, sweep_ptr SHALL start at 0 and increment each cycle; after the cycle with sweep_ptr=2^INDEX_LEN-1, the FSM SHALL clear sweep_pending, reset sweep_ptr to 0, and go to IDLE.
REQ-032 SWEEP SHALL last exactly 2^INDEX_LEN cycles.
REQ-033 A counter wrap occurring during ALLOC/DECAY SHALL set pending; the sweep then starts from the following IDLE cycle.
REQ-034 LFSR SHALL be 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advancing every cycle.
REQ-035 upd_provider > N_TAGGED SHALL be treated as N_TAGGED (no action).

Reset
REQ-036 rst=0 SHALL asynchronously force state=IDLE, period counter=0, sweep_pending=0, sweep_ptr=0, lfsr=8'h01.
REQ-037 While rst=0 outputs SHALL be upd_ready=1, busy=0, alloc_we=0, useful_dec=0, useful_clr=0, tbl_index=0.
REQ-038 Reset asserted mid-ALLOC, DECAY or SWEEP SHALL abort the operation with no further strobes.

Verification
REQ-039 Allocation: provider=1, mispredict=1, useful={c2=0,c3=1,c4=2}, index=9'h05 -> next cycle alloc_we=4'b0010, tbl_index=9'h05, upd_ready=0, busy=1; then IDLE.
REQ-040 Random choice: provider=0, all useful=0; lfsr[0]=1 -> alloc_we=4'b0010; lfsr[0]=0 -> alloc_we=4'b0001.
REQ-041 Decay: provider=2, useful c3=1, c4=3, index=9'h1F0 -> 1 cycle useful_dec=4'b1100, tbl_index=9'h1F0, alloc_we=0.
REQ-042 No-op: mispredict=0, or provider=4 -> no strobes, upd_ready stays 1, busy=0.
REQ-043 Sweep with RESET_COUNTER_LEN=4, INDEX_LEN=3: after 16 cycles from reset, upd_ready=0, useful_clr=4'b1111 for 8 cycles with tbl_index 0..7, then IDLE; an upd_valid held high is accepted only after the sweep ends.
REQ-044 Reset mid-sweep (tbl_index=3): useful_clr drops to 0 immediately; after release upd_ready=1 and the period counter restarts from 0.
